riscv_core_dcache_mem_responder: RTL and testbench

RISCV_CORE_DCACHE_MEM_RESPONDER -- requirements
Module: riscv_core_dcache_mem_responder

---
 rtl/riscv_core_dcache_mem_responder.sv | 144 ++++++++++++++
 tb/tb_riscv_core_dcache_mem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_dcache_mem_responder.sv
// Backing-memory responder for the data cache: 8-beat refill reads and
// strobed single-word writes with fixed latency and range checking.
module riscv_core_dcache_mem_responder #(
  parameter int ADDR_WIDTH      = 32,
  parameter int CORE_DATA_WIDTH = 32,
  parameter int AXI_DATA_WIDTH  = 256,
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int READ_LATENCY    = 4,
  parameter int WRITE_LATENCY   = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [ADDR_WIDTH-1:0]      i_mem_read_address,
  input  logic                       i_mem_read_req,
  output logic                       o_mem_read_done,
  output logic [AXI_DATA_WIDTH-1:0]  o_block_from_axi,
  input  logic                       i_mem_write_valid,
  input  logic [ADDR_WIDTH-1:0]      i_mem_write_address,
  input  logic [CORE_DATA_WIDTH-1:0] i_mem_write_data,
  input  logic [7:0]                 i_mem_write_strobe,
  output logic                       o_mem_write_done,
  output logic                       o_resp_err,
  input  logic                       i_init_we,
  input  logic [$clog2(MEM_DEPTH_WORDS)-1:0] i_init_addr,
  input  logic [31:0]                i_init_data
);

  localparam int IW = $clog2(MEM_DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(MEM_DEPTH_WORDS);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_BURST, RD_DONE, WR_WAIT, WR_DONE
  } state_t;

  state_t r_state, w_next;

  logic [15:0]                r_cnt;
  logic [2:0]                 r_beat;
  logic [ADDR_WIDTH-1:0]      r_addr;
  logic [CORE_DATA_WIDTH-1:0] r_wdata;
  logic [7:0]                 r_strb;
  logic                       r_err;
  logic [AXI_DATA_WIDTH-1:0]  r_block;
  logic [31:0]                r_mem [MEM_DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0] w_base_idx;
  logic [ADDR_WIDTH-1:0] w_rd_idx;
  logic                  w_rd_oor;
  logic                  w_wr_oor;
  logic [31:0]           w_rd_word;
  logic                  w_cnt_zero;
  logic                  w_idle;
  logic                  w_acc_wr;
  logic                  w_acc_rd;
  logic                  w_commit;
  logic [3:0]            w_sel;
  logic                  w_unused;

  assign w_base_idx = r_addr >> 2;
  assign w_rd_idx   = w_base_idx + ADDR_WIDTH'(r_beat);
  assign w_rd_oor   = w_rd_idx >= DEPTH;
  assign w_wr_oor   = w_base_idx >= DEPTH;
  assign w_rd_word  = w_rd_oor ? 32'h0 : r_mem[w_rd_idx[IW-1:0]];
  assign w_cnt_zero = r_cnt == 16'd0;
  assign w_idle     = r_state == IDLE;
  assign w_acc_wr   = w_idle && i_mem_write_valid;
  assign w_acc_rd   = w_idle && i_mem_read_req && !i_mem_write_valid;
  // A reset landing on the commit edge must not leave a partial write.
  assign w_commit   = (r_state == WR_WAIT) && w_cnt_zero &&
                      !w_wr_oor && !i_rst;
  assign w_sel      = r_addr[2] ? r_strb[7:4] : r_strb[3:0];
  assign w_unused   = ^{r_addr[1:0], i_mem_read_address[4:0]};

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (i_mem_write_valid)   w_next = WR_WAIT;
        else if (i_mem_read_req) w_next = RD_WAIT;
      end
      RD_WAIT:  if (w_cnt_zero) w_next = RD_BURST;
      RD_BURST: if (r_beat == 3'd7) w_next = RD_DONE;
      RD_DONE:  w_next = IDLE;
      WR_WAIT:  if (w_cnt_zero) w_next = WR_DONE;
      WR_DONE:  w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_beat  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_err   <= 1'b0;
      r_block <= '0;
    end else begin
      if (w_acc_wr) begin
        r_addr  <= i_mem_write_address;
        r_wdata <= i_mem_write_data;
        r_strb  <= i_mem_write_strobe;
        r_cnt   <= 16'(WRITE_LATENCY - 1);
        r_err   <= 1'b0;
      end else if (w_acc_rd) begin
        r_addr  <= {i_mem_read_address[ADDR_WIDTH-1:5], 5'b0};
        r_cnt   <= 16'(READ_LATENCY - 1);
        r_beat  <= 3'd0;
        r_err   <= 1'b0;
      end
      if ((r_state == RD_WAIT || r_state == WR_WAIT) && !w_cnt_zero)
        r_cnt <= r_cnt - 16'd1;
      if (r_state == WR_WAIT && w_cnt_zero)
        r_err <= w_wr_oor;
      if (r_state == RD_BURST) begin
        r_block[{r_beat, 5'b0} +: 32] <= w_rd_word;
        r_err <= r_err | w_rd_oor;
        if (r_beat != 3'd7) r_beat <= r_beat + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_idle && i_init_we)
      r_mem[i_init_addr] <= i_init_data;
    if (w_commit) begin
      for (int j = 0; j < 4; j++)
        if (w_sel[j])
          r_mem[w_base_idx[IW-1:0]][8*j +: 8] <= r_wdata[8*j +: 8];
    end
  end

  assign o_mem_read_done  = r_state == RD_DONE;
  assign o_mem_write_done = r_state == WR_DONE;
  assign o_resp_err       = r_err && (o_mem_read_done || o_mem_write_done);
  assign o_block_from_axi = r_block;

endmodule

// File: tb/tb_riscv_core_dcache_mem_responder.sv
// Directed bench for the dcache memory responder: table-driven write/read
// vectors plus hand-written multi-cycle sequences.
module tb_riscv_core_dcache_mem_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  rd_addr;
  logic         rd_req;
  logic         rd_done;
  logic [255:0] block;
  logic         wr_valid;
  logic [31:0]  wr_addr;
  logic [31:0]  wr_data;
  logic [7:0]   wr_strb;
  logic         wr_done;
  logic         resp_err;
  logic         init_we;
  logic [9:0]   init_addr;
  logic [31:0]  init_data;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  riscv_core_dcache_mem_responder dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_mem_read_address  (rd_addr),
    .i_mem_read_req      (rd_req),
    .o_mem_read_done     (rd_done),
    .o_block_from_axi    (block),
    .i_mem_write_valid   (wr_valid),
    .i_mem_write_address (wr_addr),
    .i_mem_write_data    (wr_data),
    .i_mem_write_strobe  (wr_strb),
    .o_mem_write_done    (wr_done),
    .o_resp_err          (resp_err),
    .i_init_we           (init_we),
    .i_init_addr         (init_addr),
    .i_init_data         (init_data)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  strb;
    logic [31:0] exp_word;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [255:0] got,
                     input logic [255:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  task automatic wait_done(input bit is_rd, output int edges);
    edges = -1;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      @(negedge clk);
      if ((is_rd ? rd_done : wr_done) === 1'b1) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic init_word(input int idx, input logic [31:0] d);
    init_we   = 1'b1;
    init_addr = 10'(idx);
    init_data = d;
    @(posedge clk);
    @(negedge clk);
    init_we = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [255:0] b,
                         output logic e, output int lat);
    rd_addr = a;
    rd_req  = 1'b1;
    wait_done(1'b1, lat);
    b = block;
    e = resp_err;
    rd_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [7:0] s, output logic e,
                          output int lat);
    wr_addr  = a;
    wr_data  = d;
    wr_strb  = s;
    wr_valid = 1'b1;
    wait_done(1'b0, lat);
    e = resp_err;
    wr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [255:0] b;
    logic [255:0] exp_blk;
    logic [31:0]  w;
    logic         e;
    int           lat;
    bit           seen;

    vecs[0] = '{32'h8,    32'h12345678, 8'h03, 32'hAABB5678, 1'b0};
    vecs[1] = '{32'hC,    32'hFFFFFFFF, 8'hF0, 32'hFFFFFFFF, 1'b0};
    vecs[2] = '{32'h10,   32'hDEADBEEF, 8'h0F, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{32'h14,   32'hCAFEF00D, 8'h0F, 32'h66666666, 1'b0};
    vecs[4] = '{32'h18,   32'h01020304, 8'h24, 32'h77027777, 1'b0};
    vecs[5] = '{32'h1C,   32'hA0B0C0D0, 8'h90, 32'hA08888D0, 1'b0};
    vecs[6] = '{32'h1000, 32'h12345678, 8'hFF, 32'h00000000, 1'b1};

    rst = 1'b1; rd_addr = '0; rd_req = 1'b0; wr_valid = 1'b0;
    wr_addr = '0; wr_data = '0; wr_strb = '0;
    init_we = 1'b0; init_addr = '0; init_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_done", 256'(rd_done), 256'(0));
    chk("rst_wr_done", 256'(wr_done), 256'(0));
    chk("rst_err", 256'(resp_err), 256'(0));
    chk("rst_block", block, 256'(0));
    rst = 1'b0;

    for (int k = 0; k < 8; k++) init_word(k, 32'h11111111 * (k + 1));
    exp_blk = '0;
    for (int k = 0; k < 8; k++)
      exp_blk[32*k +: 32] = 32'h11111111 * (k + 1);
    do_read(32'h14, b, e, lat);
    chk("rd_base_lat", 256'(lat), 256'(12));
    chk("rd_base_blk", b, exp_blk);
    chk("rd_base_err", 256'(e), 256'(0));

    init_word(2, 32'hAABBCCDD);
    for (int i = 0; i < 7; i++) begin
      do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, e, lat);
      chk($sformatf("wr%0d_lat", i), 256'(lat), 256'(2));
      chk($sformatf("wr%0d_err", i), 256'(e), 256'(vecs[i].exp_err));
      do_read(vecs[i].addr, b, e, lat);
      w = b[32*vecs[i].addr[4:2] +: 32];
      chk($sformatf("wr%0d_word", i), 256'(w), 256'(vecs[i].exp_word));
      chk($sformatf("wr%0d_rderr", i), 256'(e), 256'(vecs[i].exp_err));
    end

    do_read(32'h1000, b, e, lat);
    chk("oor_rd_lat", 256'(lat), 256'(12));
    chk("oor_rd_blk", b, 256'(0));
    chk("oor_rd_err", 256'(e), 256'(1));

    rd_addr = 32'h20; rd_req = 1'b1;
    wr_addr = 32'h20; wr_data = 32'h5A5A5A5A; wr_strb = 8'h0F;
    wr_valid = 1'b1;
    wait_done(1'b0, lat);
    chk("prio_wr_lat", 256'(lat), 256'(2));
    chk("prio_no_rd_yet", 256'(rd_done), 256'(0));
    wr_valid = 1'b0;
    wait_done(1'b1, lat);
    chk("prio_rd_lat", 256'(lat), 256'(13));
    chk("prio_rd_word", 256'(block[31:0]), 256'(32'h5A5A5A5A));
    rd_req = 1'b0;
    @(posedge clk);
    @(negedge clk);

    rd_addr = 32'h0; rd_req = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; rd_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_block", block, 256'(0));
    chk("midrst_done", 256'(rd_done), 256'(0));
    chk("midrst_err", 256'(resp_err), 256'(0));
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_done === 1'b1) seen = 1'b1;
    end
    chk("midrst_no_done", 256'(seen), 256'(0));
    do_read(32'h0, b, e, lat);
    chk("postrst_lat", 256'(lat), 256'(12));
    chk("postrst_word0", 256'(b[31:0]), 256'(32'h11111111));

    rd_addr = 32'h0; rd_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init_we = 1'b1; init_addr = 10'd1; init_data = 32'hBADBAD00;
    @(posedge clk);
    @(negedge clk);
    init_we = 1'b0;
    wait_done(1'b1, lat);
    chk("initwait_lat", 256'(lat), 256'(10));
    chk("initwait_word1", 256'(block[63:32]), 256'(32'h22222222));
    rd_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    do_read(32'h4, b, e, lat);
    chk("initwait_reread", 256'(b[63:32]), 256'(32'h22222222));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
